// File: rtl/clk_en_sched_if.sv
// -----------------------------------------------------------------------------
// clk_en_sched_if
//
// Bundles the control and status signals of the clock-enable scheduler.
//
// Signals (directions as seen from the scheduler, i.e. the slave modport):
//   run_i       in   level request for free-running enables
//   step_req_i  in   one-cycle pulse requesting exactly one enable
//   div_wr_i    in   one-cycle divisor write strobe
//   div_i       in   divisor write data (DIV_W bits)
//   div_ack_o   out  one-cycle pulse when a written divisor takes effect
//   ce_o        out  clock enable, one cycle high per period
//   phase_o     out  square wave, toggles after every ce_o cycle
//   state_o     out  scheduler FSM state (IDLE=00, RUN=01, STEP=10)
//   busy_o      out  high whenever the FSM is not IDLE
//
// Modports:
//   master  debug/control side that drives requests and observes status
//   slave   the scheduler itself
// -----------------------------------------------------------------------------
interface clk_en_sched_if #(
    parameter int DIV_W = 8
);
    logic             run_i;
    logic             step_req_i;
    logic             div_wr_i;
    logic [DIV_W-1:0] div_i;
    logic             div_ack_o;
    logic             ce_o;
    logic             phase_o;
    logic [1:0]       state_o;
    logic             busy_o;

    modport master (
        output run_i,
        output step_req_i,
        output div_wr_i,
        output div_i,
        input  div_ack_o,
        input  ce_o,
        input  phase_o,
        input  state_o,
        input  busy_o
    );

    modport slave (
        input  run_i,
        input  step_req_i,
        input  div_wr_i,
        input  div_i,
        output div_ack_o,
        output ce_o,
        output phase_o,
        output state_o,
        output busy_o
    );
endinterface

// File: rtl/clk_en_sched.sv
// -----------------------------------------------------------------------------
// clk_en_sched
//
// Programmable clock-enable scheduler for the core datapath. Instead of
// divided clocks, it produces a single-cycle enable pulse (ce_o) on the system
// clock every div_q+1 cycles, plus a square wave (phase_o) that toggles after
// each enable. Enables run freely while run_i is high, or a single enable can
// be requested with step_req_i. The divisor can be rewritten at any time; the
// new value is held pending and only takes effect at a period boundary so a
// period is never cut short or stretched.
//
// Optional feature: define CLK_SCHED_STEP_EN to enable single-step. When it is
// not defined, step_req_i is ignored and the STEP state is never entered.
//
// Parameters:
//   DIV_W    width of the divisor; the enable period is div+1 cycles
//   DIV_RST  divisor value loaded on reset
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   clk_en_sched_if.slave (run/step requests, divisor write, status)
//
// Divisor write handshake: div_wr_i is a one-cycle strobe qualifying div_i and
// needs no ready; the scheduler always accepts it. A later strobe before the
// apply point replaces the earlier data. div_ack_o is a one-cycle pulse in the
// cycle after the edge where the most recent written value reached div_q;
// several overwritten writes yield a single ack.
// -----------------------------------------------------------------------------
module clk_en_sched #(
    parameter int DIV_W   = 8,
    parameter int DIV_RST = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    clk_en_sched_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10
    } state_t;

    localparam logic [DIV_W-1:0] DIV_RST_V = DIV_W'(DIV_RST);
    localparam logic [DIV_W-1:0] CNT_ONE   = DIV_W'(1);

    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] pend_q;
    logic             pend_v;
    logic             phase_q;
    logic             ack_q;

    logic             ce;
    logic             apply;
    logic             step_go;

`ifdef CLK_SCHED_STEP_EN
    assign step_go = bus.step_req_i;
`else
    // Single-step is compiled out; the request is deliberately dropped.
    logic unused_step_req;
    assign unused_step_req = bus.step_req_i;
    assign step_go         = 1'b0;
`endif

    // The enable is decoded from registered state only, so it is glitch-free
    // relative to the clock and stays high for exactly the one cycle where
    // the counter sits on the divisor.
    assign ce = (state != IDLE) && (cnt == div_q);

    // Period boundaries: every edge in IDLE (counter parked at 0) and every
    // enable edge (counter about to return to 0). Loading div_q only here
    // keeps cnt <= div_q at all times.
    assign apply = (state == IDLE) || ce;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            div_q   <= DIV_RST_V;
            pend_q  <= '0;
            pend_v  <= 1'b0;
            phase_q <= 1'b1;
            ack_q   <= 1'b0;
        end else begin
            if (ce) begin
                phase_q <= ~phase_q;
            end

            // A write landing exactly on the apply edge bypasses the pending
            // register so the freshest value always wins.
            if (apply) begin
                ack_q  <= bus.div_wr_i | pend_v;
                pend_v <= 1'b0;
                if (bus.div_wr_i) begin
                    div_q <= bus.div_i;
                end else if (pend_v) begin
                    div_q <= pend_q;
                end
            end else begin
                ack_q <= 1'b0;
                if (bus.div_wr_i) begin
                    pend_q <= bus.div_i;
                    pend_v <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.run_i) begin
                        state <= RUN;
                    end else if (step_go) begin
                        state <= STEP;
                    end
                end
                RUN: begin
                    // Dropping run_i only takes effect at the end of a period,
                    // so the current period always completes.
                    if (ce) begin
                        cnt <= '0;
                        if (!bus.run_i) begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STEP: begin
                    if (ce) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ce_o      = ce;
    assign bus.phase_o   = phase_q;
    assign bus.div_ack_o = ack_q;
    assign bus.state_o   = state;
    assign bus.busy_o    = (state != IDLE);

endmodule

// File: tb/tb_clk_en_sched.sv
module tb_clk_en_sched;
  localparam int DIV_W = 8;
  localparam int DIV_RST = 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clk_en_sched_if #(.DIV_W(DIV_W)) bus ();

  clk_en_sched #(.DIV_W(DIV_W), .DIV_RST(DIV_RST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  // scoreboard: expected enable cycles / ack cycles vs observed ones
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  logic [31:0] exp_ack_q[$];
  logic [31:0] ack_q[$];

  // advance n clock edges; sample on the falling edge and log events
  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (bus.ce_o === 1'b1) obs_q.push_back(cyc);
      if (bus.div_ack_o === 1'b1) ack_q.push_back(cyc);
    end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    exp_ack_q.delete();
    ack_q.delete();
  endtask

  task automatic do_reset();
    bus.run_i = 1'b0;
    bus.step_req_i = 1'b0;
    bus.div_wr_i = 1'b0;
    bus.div_i = '0;
    rst = 1'b1;
    adv(2);
    rst = 1'b0;
    adv(1);
    clear_sb();
  endtask

  // write divisor while IDLE (applies on the next edge)
  task automatic set_div(input logic [DIV_W-1:0] v);
    bus.div_i = v;
    bus.div_wr_i = 1'b1;
    adv(1);
    bus.div_wr_i = 1'b0;
    adv(1);
    clear_sb();
  endtask

  task automatic test_reset();
    bus.run_i = 1'b0;
    bus.step_req_i = 1'b0;
    bus.div_wr_i = 1'b0;
    bus.div_i = '0;
    rst = 1'b1;
    #1;
    checks++; if (bus.ce_o !== 1'b0) begin errors++; $display("FAIL reset_ce got=%b exp=0", bus.ce_o); end
    checks++; if (bus.phase_o !== 1'b1) begin errors++; $display("FAIL reset_phase got=%b exp=1", bus.phase_o); end
    checks++; if (bus.div_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", bus.div_ack_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
    checks++; if (bus.state_o !== 2'b00) begin errors++; $display("FAIL reset_state got=%b exp=00", bus.state_o); end
    adv(2);
    rst = 1'b0;
    adv(1);
    clear_sb();
  endtask

  // div_q = 1: enables after E1, E3, E5; phase 1 -> 0 -> 1
  task automatic test_run_basic();
    int e0, k;
    do_reset();
    bus.run_i = 1'b1;
    e0 = cyc + 1;
    exp_q.push_back(e0 + 1);
    exp_q.push_back(e0 + 3);
    exp_q.push_back(e0 + 5);
    for (int i = 0; i < 6; i++) begin
      adv(1);
      k = cyc - e0;
      checks++;
      if (bus.phase_o !== ((((k / 2) % 2) == 0) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL run_phase k=%0d got=%b", k, bus.phase_o);
      end
      if (k == 2) begin
        checks++; if (bus.state_o !== 2'b01) begin errors++; $display("FAIL run_state got=%b exp=01", bus.state_o); end
        checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL run_busy got=%b exp=1", bus.busy_o); end
      end
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL run_ce_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [31:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL run_ce_cycle got=%0d exp=%0d", o, e); end
    end
    bus.run_i = 1'b0;
    adv(4);
  endtask

  // divisor 1 -> 3 written mid-period; applies at the next enable edge
  task automatic test_div_change();
    int e0, k;
    do_reset();
    bus.run_i = 1'b1;
    e0 = cyc + 1;
    exp_q.push_back(e0 + 1);
    exp_q.push_back(e0 + 3);
    exp_q.push_back(e0 + 7);
    exp_q.push_back(e0 + 11);
    exp_ack_q.push_back(e0 + 4);
    for (int i = 0; i < 13; i++) begin
      adv(1);
      k = cyc - e0;
      bus.div_wr_i = (k == 2);
      bus.div_i = 8'd3;
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL divchg_ce_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [31:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL divchg_ce_cycle got=%0d exp=%0d", o, e); end
    end
    checks++;
    if (ack_q.size() != exp_ack_q.size()) begin
      errors++; $display("FAIL divchg_ack_count got=%0d exp=%0d", ack_q.size(), exp_ack_q.size());
    end
    while (exp_ack_q.size() > 0 && ack_q.size() > 0) begin
      logic [31:0] e, o;
      e = exp_ack_q.pop_front(); o = ack_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL divchg_ack_cycle got=%0d exp=%0d", o, e); end
    end
    bus.run_i = 1'b0;
    adv(6);
  endtask

  // div_q = 4: run drops after an enable; the current period still completes
  task automatic test_run_drop();
    int e0, k;
    do_reset();
    set_div(8'd4);
    bus.run_i = 1'b1;
    e0 = cyc + 1;
    exp_q.push_back(e0 + 4);
    exp_q.push_back(e0 + 9);
    for (int i = 0; i < 15; i++) begin
      adv(1);
      k = cyc - e0;
      if (k == 10) begin
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL drop_busy got=%b exp=0", bus.busy_o); end
        checks++; if (bus.state_o !== 2'b00) begin errors++; $display("FAIL drop_state got=%b exp=00", bus.state_o); end
      end
      if (k == 5) bus.run_i = 1'b0;
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL drop_ce_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [31:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL drop_ce_cycle got=%0d exp=%0d", o, e); end
    end
  endtask

  // single-cycle run_i dip away from an enable edge changes nothing
  task automatic test_run_glitch();
    int e0, k;
    do_reset();
    bus.run_i = 1'b1;
    e0 = cyc + 1;
    for (int j = 0; j < 4; j++) exp_q.push_back(e0 + 1 + 2 * j);
    for (int i = 0; i < 8; i++) begin
      adv(1);
      k = cyc - e0;
      bus.run_i = (k != 2);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL glitch_ce_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [31:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL glitch_ce_cycle got=%0d exp=%0d", o, e); end
    end
    bus.run_i = 1'b0;
    adv(4);
  endtask

  // step request with div_q = 2; a second request while stepping is ignored
  task automatic test_step();
    int e0, k;
    do_reset();
    set_div(8'd2);
    bus.step_req_i = 1'b1;
    e0 = cyc + 1;
`ifdef CLK_SCHED_STEP_EN
    exp_q.push_back(e0 + 2);
`endif
    for (int i = 0; i < 9; i++) begin
      adv(1);
      k = cyc - e0;
      bus.step_req_i = (k == 0);
`ifdef CLK_SCHED_STEP_EN
      if (k == 1) begin
        checks++; if (bus.state_o !== 2'b10) begin errors++; $display("FAIL step_state got=%b exp=10", bus.state_o); end
      end
      if (k == 4) begin
        checks++; if (bus.state_o !== 2'b00) begin errors++; $display("FAIL step_idle got=%b exp=00", bus.state_o); end
      end
`else
      checks++; if (bus.state_o !== 2'b00) begin errors++; $display("FAIL step_off_state k=%0d got=%b exp=00", k, bus.state_o); end
`endif
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL step_ce_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [31:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL step_ce_cycle got=%0d exp=%0d", o, e); end
    end
  endtask

  // two writes in one period give one ack; a write on an enable edge applies there
  task automatic test_back_to_back();
    int e0, k;
    do_reset();
    set_div(8'd4);
    bus.run_i = 1'b1;
    e0 = cyc + 1;
    exp_q.push_back(e0 + 4);
    exp_q.push_back(e0 + 12);
    exp_q.push_back(e0 + 16);
    exp_q.push_back(e0 + 20);
    exp_ack_q.push_back(e0 + 5);
    exp_ack_q.push_back(e0 + 13);
    for (int i = 0; i < 22; i++) begin
      adv(1);
      k = cyc - e0;
      bus.div_wr_i = (k == 0) || (k == 1) || (k == 12);
      bus.div_i = (k == 0) ? 8'd5 : (k == 1) ? 8'd7 : 8'd3;
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_ce_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [31:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL b2b_ce_cycle got=%0d exp=%0d", o, e); end
    end
    checks++;
    if (ack_q.size() != exp_ack_q.size()) begin
      errors++; $display("FAIL b2b_ack_count got=%0d exp=%0d", ack_q.size(), exp_ack_q.size());
    end
    while (exp_ack_q.size() > 0 && ack_q.size() > 0) begin
      logic [31:0] e, o;
      e = exp_ack_q.pop_front(); o = ack_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL b2b_ack_cycle got=%0d exp=%0d", o, e); end
    end
    bus.run_i = 1'b0;
    adv(6);
  endtask

  // asynchronous reset mid-period with a write pending
  task automatic test_reset_mid();
    int e0, k;
    do_reset();
    set_div(8'd4);
    bus.run_i = 1'b1;
    e0 = cyc + 1;
    for (int i = 0; i < 8; i++) begin
      adv(1);
      k = cyc - e0;
      bus.div_wr_i = (k == 6);
      bus.div_i = 8'd9;
    end
    #2;
    rst = 1'b1;
    bus.run_i = 1'b0;
    bus.div_wr_i = 1'b0;
    #1;
    checks++; if (bus.phase_o !== 1'b1) begin errors++; $display("FAIL rstmid_phase got=%b exp=1", bus.phase_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy_o); end
    checks++; if (bus.ce_o !== 1'b0) begin errors++; $display("FAIL rstmid_ce got=%b exp=0", bus.ce_o); end
    checks++; if (bus.div_ack_o !== 1'b0) begin errors++; $display("FAIL rstmid_ack got=%b exp=0", bus.div_ack_o); end
    clear_sb();
    adv(2);
    rst = 1'b0;
    adv(3);
    checks++;
    if (ack_q.size() != 0) begin errors++; $display("FAIL rstmid_no_ack got=%0d exp=0", ack_q.size()); end
    // divisor must be back at DIV_RST (=1): enables every other cycle
    clear_sb();
    bus.run_i = 1'b1;
    e0 = cyc + 1;
    exp_q.push_back(e0 + 1);
    exp_q.push_back(e0 + 3);
    adv(4);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rstmid_ce_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [31:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL rstmid_ce_cycle got=%0d exp=%0d", o, e); end
    end
    bus.run_i = 1'b0;
    adv(4);
  endtask

  initial begin
    rst = 1'b1;
    bus.run_i = 1'b0;
    bus.step_req_i = 1'b0;
    bus.div_wr_i = 1'b0;
    bus.div_i = '0;
    test_reset();
    test_run_basic();
    test_div_change();
    test_run_drop();
    test_run_glitch();
    test_step();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_en_sched.md
# clk_en_sched

Programmable clock-enable scheduler that sequences when the RV32IC core datapath advances. It replaces free-running divided clocks with a single-cycle enable pulse `ce_o` on the system clock, plus a square-wave `phase_o`. It adds run/stop control, optional single-step, and a divisor register that changes safely at period boundaries. It sits between the debug/control logic and every clock-enabled register in the core.

## Interface
- `DIV_W`, 8: width of the divisor; the enable period is `div+1` cycles.
- `DIV_RST`, 1: divisor value loaded on reset.

- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `run_i` in 1: level request for free-running enables.
- `step_req_i` in 1: one-cycle pulse requesting exactly one enable.
- `div_wr_i` in 1: one-cycle divisor write strobe.
- `div_i` in DIV_W: divisor write data.
- `div_ack_o` out 1: one-cycle pulse when a written divisor takes effect.
- `ce_o` out 1: clock enable, high for exactly one cycle per period.
- `phase_o` out 1: toggles after each `ce_o` cycle.
- `state_o` out 2: FSM state (IDLE=00, RUN=01, STEP=10).
- `busy_o` out 1: high when state is not IDLE.

## Operation
- Registers:
  - `state`
  - `cnt[DIV_W-1:0]`
  - `div_q`
  - `pend_q[DIV_W-1:0]`, with valid flag `pend_v`
  - `phase_o`
  - `div_ack_o`
- IDLE:
  - `cnt` is held at 0 and `ce_o` is 0.
  - If `run_i`=1, go to RUN. Otherwise, if `step_req_i`=1, go to STEP. `run_i` wins if both are high.
- RUN:
  - `cnt` increments each cycle.
  - `ce_o` = (`cnt`==`div_q`), combinational from registered state.
  - On a `ce_o` edge, `cnt` goes to 0.
  - On a `ce_o` edge with `run_i`=0, go to IDLE. `run_i` falling mid-period therefore finishes the current period.
  - `step_req_i` is ignored.
- STEP:
  - Counts like RUN and emits one `ce_o`, then goes to IDLE.
  - `run_i` and `step_req_i` are ignored until back in IDLE.
- `phase_o` toggles on every edge where `ce_o`=1.
- Divisor write:
  - `div_wr_i` loads `pend_q` and sets `pend_v`. A second write before the apply point overwrites `pend_q`.
  - The apply point is any edge in IDLE, or any edge where `ce_o`=1.
  - At the apply point, if `div_wr_i` is high, `div_i` goes straight to `div_q`. Otherwise, if `pend_v` is set, `pend_q` goes to `div_q`.
  - Applying clears `pend_v` and sets `div_ack_o` for the next cycle. Several overwritten writes produce one ack.
- `div_q`=0: `ce_o` is high every cycle in RUN, and `phase_o` runs at `clk`/2.
- Counter arithmetic is unsigned DIV_W bits. `cnt` never exceeds `div_q` because a new divisor only loads when `cnt` is 0.

## Timing
- Reset values:
  - `state`=IDLE, `cnt`=0, `div_q`=DIV_RST, `pend_v`=0.
  - `phase_o`=1, `ce_o`=0, `div_ack_o`=0, `busy_o`=0, `state_o`=00.
- `run_i` sampled high at edge E0: RUN from E0. The first `ce_o` falls in the cycle after edge E0+`div_q`, i.e. `div_q`+1 cycles after E0. Later pulses are every `div_q`+1 cycles.
- Step latency: the same as the first RUN pulse, and exactly one pulse.
- `div_ack_o` is registered: high in the cycle after the apply edge.
- A reset asserted mid-period forces all reset values immediately. A pending write is discarded and no ack is produced.
- `run_i` low for one cycle that does not coincide with a `ce_o` cycle has no effect.

## Configuration
- `CLK_SCHED_STEP_EN` defined:
  - STEP state and `step_req_i` behave as above.
- Undefined:
  - `step_req_i` is ignored.
  - STEP is unreachable; `state_o` is never 10.
  - All other behaviour is identical.

## Test plan
- Reset, then `run_i`=1 at E0 with `div_q`=1: `ce_o` high on the cycles after E1, E3, E5. `phase_o` goes 1→0→1.
- `div_wr_i` with `div_i`=3 mid-period in RUN (`div_q`=1): the old period completes; `div_ack_o` pulses one cycle after that `ce_o` edge; the next periods are 4 cycles.
- `run_i` drops one cycle after a `ce_o` with `div_q`=4: one more `ce_o` occurs 4 cycles later, then IDLE with `busy_o`=0.
- `step_req_i` in IDLE with `div_q`=2 (macro on): exactly one `ce_o`, 3 cycles after the request edge, then IDLE. With the macro off: no `ce_o` and `state_o` stays 00.
- Two writes (5 then 7) inside one RUN period: `div_q`=7 after the boundary and one `div_ack_o`. A write coinciding with a `ce_o` edge applies at that edge.
- `rst` pulsed mid-period with a write pending: all outputs go to reset values, `div_q`=DIV_RST, no ack.
